word_accumulator: RTL and testbench
===================================

// Module: word_accumulator
// PURPOSE
//  Self-contained datapath test block: a 4-entry word sequencer drives a WIDTH-bit
//  accumulator with carry-out. Used in the RAM BIST area to prove adder/sequencing
//  logic before pattern words are fed to memory. One clock domain, no handshake.
// PARAMETERS
//  WIDTH   3                         accumulator/word width in bits (>=2)
//  NWORDS  4                         number of words in generator sequence (>=1)
//  SEQ     {3'b100,3'b011,3'b111,3'b010}  packed NWORDS*WIDTH sequence, entry 0 in LSBs
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset
//  clear     in   1      synchronous clear of sum/carry (not generator)
//  acc_en    in   1      accumulate enable
//  gen_next  in   1      advance generator to next word (synchronous enable)
//  word      out  WIDTH  current generator word (accumulator operand)
//  sum       out  WIDTH  accumulator register
//  carry     out  1      carry/overflow flag
// BEHAVIOUR
//  - reset low (async): gen index=0 (word=SEQ[0]=010), sum=0, carry=0; held while low.
//  - word = SEQ[index], combinational from index register; no latency.
//  - Per rising clk edge (reset high), priority clear > acc_en:
//      clear=1: sum<=0, carry<=0.
//      acc_en=1: {carry,sum} <= {1'b0,sum} + {1'b0,word} (WIDTH+1-bit add; carry
//        reflects this addition only, cleared if no carry-out).
//      neither: sum, carry hold.
//  - gen_next=1 on an edge: index<=index+1, wraps NWORDS-1 -> 0. Independent of
//    clear/acc_en; same-edge accumulate uses the pre-advance word.
//  - Simultaneous clear+gen_next: sum cleared AND index advances.
//  - Sum wraps modulo 2^WIDTH (default build).
// CONFIGURATION
//  ACC_SATURATE_EN defined: add saturates; if sum+word >= 2^WIDTH then sum<=all-ones
//    and carry<=1 sticky (stays 1 until clear or reset). Not defined: modulo wrap,
//    carry per-addition as above.
// STRUCTURE
//  - Package word_acc_pkg: DEF_WIDTH=3, DEF_NWORDS=4, DEF_SEQ constant, sum_t typedef.
//  - Sub-module word_sequencer (index counter + SEQ mux, outputs word); accumulator
//    register/adder/carry logic in top.
// TESTING
//  1 reset low mid-run with sum=110 -> sum=000, carry=0, word=010 immediately.
//  2 acc_en=1, gen_next=0, 4 clks -> sum 010,100,110,000; carry 0,0,0,1.
//  3 acc_en=1, gen_next=1, 5 clks -> word 010,111,011,100,010; sum 010,001,100,000,010;
//    carry 0,1,0,1,0.
//  4 clear=1 with acc_en=1,gen_next=1 -> sum=0, carry=0, index advances by 1.
//  5 acc_en=0, gen_next=0 for 3 clks -> sum/carry/word stable.
//  6 ACC_SATURATE_EN, sum=110, word=010, acc_en -> sum=111, carry=1; next add keeps 111/1.

Source files
------------

// File: rtl/word_acc_pkg.sv
// Shared defaults for the word accumulator test block: operand width,
// generator length and the default generator sequence (entry 0 in LSBs).
package word_acc_pkg;
  localparam int DEF_WIDTH  = 3;
  localparam int DEF_NWORDS = 4;
  localparam logic [DEF_NWORDS*DEF_WIDTH-1:0] DEF_SEQ = {3'b100, 3'b011, 3'b111, 3'b010};

  typedef logic [DEF_WIDTH-1:0] sum_t;
endpackage

// File: rtl/word_accumulator_if.sv
// Control/observation bundle for word_accumulator.
// master: the controller (drives clear/acc_en/gen_next).
// slave : the accumulator block (drives word/sum/carry).
interface word_accumulator_if
  import word_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             clear;
  logic             acc_en;
  logic             gen_next;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (output clear, acc_en, gen_next, input word, sum, carry);
  modport slave  (input clear, acc_en, gen_next, output word, sum, carry);
endinterface

// File: rtl/word_sequencer.sv
// Word generator: an index counter that wraps at NWORDS-1 and a mux that
// presents SEQ[index] combinationally, so the word changes on the same edge
// the index advances.
module word_sequencer
  import word_acc_pkg::*;
#(
  parameter int                          WIDTH  = DEF_WIDTH,
  parameter int                          NWORDS = DEF_NWORDS,
  parameter logic [NWORDS*WIDTH-1:0]     SEQ    = DEF_SEQ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gen_next,
  output logic [WIDTH-1:0] word
);
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

  logic [NWORDS-1:0][WIDTH-1:0] seq_arr;
  logic [IDX_W-1:0]             idx;

  assign seq_arr = SEQ;

  // index advance with wrap back to entry 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        idx <= '0;
    else if (gen_next) idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
  end

  assign word = seq_arr[idx];
endmodule

// File: rtl/word_accumulator.sv
// Accumulator test block: word_sequencer feeds a WIDTH-bit adder with
// carry-out. clear beats acc_en; the generator advances independently, so a
// same-edge accumulate always uses the pre-advance word.
// Build option: ACC_SATURATE_EN -- saturating add with a sticky carry flag
// (default: modulo wrap, carry reflects the latest addition only).
module word_accumulator
  import word_acc_pkg::*;
#(
  parameter int                      WIDTH  = DEF_WIDTH,
  parameter int                      NWORDS = DEF_NWORDS,
  parameter logic [NWORDS*WIDTH-1:0] SEQ    = DEF_SEQ
) (
  input  logic               clk,
  input  logic               reset,
  word_accumulator_if.slave  bus
);
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [WIDTH:0]   add_full;

  word_sequencer #(
    .WIDTH  (WIDTH),
    .NWORDS (NWORDS),
    .SEQ    (SEQ)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .gen_next (bus.gen_next),
    .word     (bus.word)
  );

  // one extra bit holds the carry-out of sum + word
  assign add_full = {1'b0, sum_q} + {1'b0, bus.word};

  // accumulator register: clear has priority over accumulate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (bus.clear) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (bus.acc_en) begin
`ifdef ACC_SATURATE_EN
      if (add_full[WIDTH]) begin
        sum_q   <= '1;
        carry_q <= 1'b1;
      end else begin
        // carry is sticky: only clear or reset drops it
        sum_q   <= add_full[WIDTH-1:0];
      end
`else
      {carry_q, sum_q} <= add_full;
`endif
    end
  end

  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
endmodule

// File: tb/tb_word_accumulator.sv
// Directed bench for word_accumulator (default sequence 010,111,011,100).
// Expectations are hand-computed; the saturating build swaps in its own table.
module tb_word_accumulator;
  import word_acc_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  word_accumulator_if #(.WIDTH(DEF_WIDTH)) bus ();

  word_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected values for the acc_en+gen_next run starting from sum 0, index 0
  sum_t t3_word [5] = '{3'b010, 3'b111, 3'b011, 3'b100, 3'b010};
`ifdef ACC_SATURATE_EN
  sum_t t2_sum  [4] = '{3'b010, 3'b100, 3'b110, 3'b111};
  logic t2_cy   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  sum_t t3_sum  [5] = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b111};
  logic t3_cy   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  sum_t t4_sum      = 3'b111;   // 111 + 111 saturates
  logic t4_cy       = 1'b1;
  sum_t t6_sum  [2] = '{3'b111, 3'b111};
  logic t6_cy   [2] = '{1'b1, 1'b1};
`else
  sum_t t2_sum  [4] = '{3'b010, 3'b100, 3'b110, 3'b000};
  logic t2_cy   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  sum_t t3_sum  [5] = '{3'b010, 3'b001, 3'b100, 3'b000, 3'b010};
  logic t3_cy   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  sum_t t4_sum      = 3'b001;   // 010 + 111 = 1_001
  logic t4_cy       = 1'b1;
  sum_t t6_sum  [2] = '{3'b000, 3'b010};
  logic t6_cy   [2] = '{1'b1, 1'b0};
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic drive(input logic c, input logic a, input logic g);
    bus.clear    = c;
    bus.acc_en   = a;
    bus.gen_next = g;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_sum",   bus.sum,   8'd0);
    chk("rst_carry", bus.carry, 8'd0);
    chk("rst_word",  bus.word,  8'b010);
    reset = 1'b1;

    // build sum=110, then move generator to entry 1
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("pre_rst_sum",  bus.sum,  8'b110);
    chk("pre_rst_word", bus.word, 8'b111);

    // 1: async reset mid-cycle takes effect without a clock edge
    drive(1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    chk("t1_sum",   bus.sum,   8'd0);
    chk("t1_carry", bus.carry, 8'd0);
    chk("t1_word",  bus.word,  8'b010);
    tick();
    chk("t1_hold_sum",  bus.sum,  8'd0);
    chk("t1_hold_word", bus.word, 8'b010);
    reset = 1'b1;

    // 2: accumulate the same word four times
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t2_sum%0d", i),   bus.sum,   8'(t2_sum[i]));
      chk($sformatf("t2_carry%0d", i), bus.carry, 8'(t2_cy[i]));
    end
    chk("t2_word", bus.word, 8'b010);

    // clear alone leaves the generator where it is
    drive(1'b1, 1'b0, 1'b0);
    tick();
    chk("clr_sum",   bus.sum,   8'd0);
    chk("clr_carry", bus.carry, 8'd0);
    chk("clr_word",  bus.word,  8'b010);

    // 3: accumulate while stepping through the sequence, including the wrap
    drive(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_word%0d", i), bus.word, 8'(t3_word[i]));
      tick();
      chk($sformatf("t3_sum%0d", i),   bus.sum,   8'(t3_sum[i]));
      chk($sformatf("t3_carry%0d", i), bus.carry, 8'(t3_cy[i]));
    end
    chk("t3_word_end", bus.word, 8'b111);

    // set carry before the clear test
    drive(1'b0, 1'b1, 1'b0);
    tick();
    chk("t4_pre_sum",   bus.sum,   8'(t4_sum));
    chk("t4_pre_carry", bus.carry, 8'(t4_cy));

    // 4: clear wins over acc_en, generator still advances
    drive(1'b1, 1'b1, 1'b1);
    tick();
    chk("t4_sum",   bus.sum,   8'd0);
    chk("t4_carry", bus.carry, 8'd0);
    chk("t4_word",  bus.word,  8'b011);

    // 5: idle holds everything
    drive(1'b0, 1'b1, 1'b0);
    tick();
    chk("t5_load", bus.sum, 8'b011);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_sum%0d", i),   bus.sum,   8'b011);
      chk($sformatf("t5_carry%0d", i), bus.carry, 8'd0);
      chk($sformatf("t5_word%0d", i),  bus.word,  8'b011);
    end

    // 6: overflow boundary from sum=110 with word=010
    drive(1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("t6_word", bus.word, 8'b010);
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("t6_pre_sum", bus.sum, 8'b110);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("t6_sum%0d", i),   bus.sum,   8'(t6_sum[i]));
      chk($sformatf("t6_carry%0d", i), bus.carry, 8'(t6_cy[i]));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
